// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 generator and self-synchronising checker with lock FSM and saturating error count.
// Latency: tx_bit registered one cycle after advance; locked rises N+LOCK_CNT cycles after chk_en in loopback.
// No backpressure: en stalls the generator, chk_en=0 parks the checker in HUNT.
module prbs_gen_chk #(
   parameter int ERR_W      = 16,
   parameter int LOCK_CNT   = 32,
   parameter int WIN        = 256,
   parameter int UNLOCK_THR = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             inv,
   input  logic             inject_err,
   output logic             tx_bit,
   input  logic             rx_bit,
   input  logic             chk_en,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);
   localparam int WB_W  = $clog2(WIN + 1);
   localparam int WE_W  = $clog2(UNLOCK_THR + 1);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state;
   logic [30:0]      g;
   logic [30:0]      c;
   logic             inj_q;
   logic [1:0]       mode_q;
   logic             mode_vld;
   logic [4:0]       n_m1;
   logic [4:0]       t_m1;
   logic [4:0]       fill;
   logic [RUN_W-1:0] run;
   logic [WB_W-1:0]  win_bits;
   logic [WE_W-1:0]  win_errs;

   // Mode change is only meaningful once a previous mode has been sampled after reset.
   logic mode_chg;
   assign mode_chg = mode_vld && (mode != mode_q);

   // Generator advances only when enabled and not being reseeded.
   logic adv;
   assign adv = en && !mode_chg;

   // Polynomial length/tap positions (as bit indices N-1 and T-1).
   always_comb begin
      n_m1 = 5'd30;
      t_m1 = 5'd27;
      case (mode)
         2'd0:    begin n_m1 = 5'd6;  t_m1 = 5'd5;  end
         2'd1:    begin n_m1 = 5'd14; t_m1 = 5'd13; end
         2'd2:    begin n_m1 = 5'd22; t_m1 = 5'd17; end
         default: begin n_m1 = 5'd30; t_m1 = 5'd27; end
      endcase
   end

   // Checker prediction and comparison; bits of c above N-1 never reach the taps.
   logic exp_bit;
   logic match;
   logic fill_done;
   logic lock_err;
   assign exp_bit   = c[n_m1] ^ c[t_m1] ^ inv;
   assign match     = (rx_bit == exp_bit);
   assign fill_done = (fill == (n_m1 + 5'd1));
   assign lock_err  = chk_en && !mode_chg && (state == LOCKED) && !match;

   assign locked = (state == LOCKED);

   // Generator LFSR, output bit and the single pending error-injection flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g        <= 31'd1;
         tx_bit   <= 1'b0;
         inj_q    <= 1'b0;
         mode_q   <= 2'd0;
         mode_vld <= 1'b0;
      end else begin
         mode_q   <= mode;
         mode_vld <= 1'b1;
         if (mode_chg) begin
            g <= 31'd1;
         end else if (en) begin
            g      <= {g[29:0], g[n_m1] ^ g[t_m1]};
            tx_bit <= g[n_m1] ^ inv ^ inj_q;
         end
         // A pending flip is consumed by the next advance; new requests are dropped while one is pending.
         if (adv && inj_q)
            inj_q <= 1'b0;
         else if (inject_err && !inj_q)
            inj_q <= 1'b1;
      end
   end

   // Checker FSM: HUNT loads c from the line, LOCKED free-runs c and watches the error window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         c         <= 31'd0;
         fill      <= 5'd0;
         run       <= '0;
         win_bits  <= '0;
         win_errs  <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (!chk_en || mode_chg) begin
            state <= HUNT;
            fill  <= 5'd0;
            run   <= '0;
         end else if (state == HUNT) begin
            c <= {c[29:0], rx_bit ^ inv};
            if (!fill_done) begin
               fill <= fill + 5'd1;
            end else if (match) begin
               run <= run + RUN_W'(1);
               if (run == RUN_W'(LOCK_CNT - 1)) begin
                  state    <= LOCKED;
                  win_bits <= '0;
                  win_errs <= '0;
               end
            end else begin
               run <= '0;
            end
         end else begin
            c <= {c[29:0], exp_bit ^ inv};
            if (!match)
               err_pulse <= 1'b1;
            if (!match && (win_errs == WE_W'(UNLOCK_THR - 1))) begin
               state    <= HUNT;
               fill     <= 5'd0;
               run      <= '0;
               win_bits <= '0;
               win_errs <= '0;
            end else if (win_bits == WB_W'(WIN - 1)) begin
               win_bits <= '0;
               win_errs <= '0;
            end else begin
               win_bits <= win_bits + WB_W'(1);
               if (!match)
                  win_errs <= win_errs + WE_W'(1);
            end
         end
      end
   end

   // Saturating error counter; a clear coinciding with an error leaves exactly that error counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= lock_err ? ERR_W'(1) : '0;
      end else if (lock_err && (err_cnt != {ERR_W{1'b1}})) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_prbs_gen_chk.sv
module tb_prbs_gen_chk;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       inv = 1'b0;
   logic       inject_err = 1'b0;
   logic       tx_bit;
   logic       rx_bit;
   logic       chk_en = 1'b0;
   logic       clr_cnt = 1'b0;
   logic       locked;
   logic       err_pulse;
   logic [3:0] err_cnt;
   logic       force0 = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   assign rx_bit = force0 ? 1'b0 : tx_bit;

   always #5 clk = ~clk;

   prbs_gen_chk #(.ERR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inv(inv),
      .inject_err(inject_err), .tx_bit(tx_bit), .rx_bit(rx_bit),
      .chk_en(chk_en), .clr_cnt(clr_cnt), .locked(locked),
      .err_pulse(err_pulse), .err_cnt(err_cnt)
   );

   typedef struct packed {
      logic en;
      logic inv;
      logic inj;
      logic exp_tx;
   } vec_t;

   vec_t vt [22];
   bit   b7  [254];
   bit   o31 [3000];

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      int pulses;
      int drops;
      int v;

      // PRBS7 from seed 1: o = 0,0,0,0,0,0,1,0,0,0,0,0,1,1,0,0,0,0,1,...
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0};
      vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1};
      vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[14] = '{1'b1, 1'b0, 1'b1, 1'b0};
      vt[15] = '{1'b1, 1'b0, 1'b1, 1'b0};
      vt[16] = '{1'b1, 1'b0, 1'b0, 1'b1};
      vt[17] = '{1'b1, 1'b1, 1'b0, 1'b1};
      vt[18] = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[19] = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[20] = '{1'b1, 1'b0, 1'b0, 1'b0};
      vt[21] = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Asynchronous reset between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx_bit", tx_bit, 0);
      check("rst_locked", locked, 0);
      check("rst_err_pulse", err_pulse, 0);
      check("rst_err_cnt", err_cnt, 0);
      step();
      step();
      rst_n = 1'b1;

      // Directed PRBS7 vectors: enable hold, inversion, injection and ignored re-injection
      for (int i = 0; i < 22; i++) begin
         en = vt[i].en;
         inv = vt[i].inv;
         inject_err = vt[i].inj;
         step();
         check($sformatf("vec%0d_tx", i), tx_bit, vt[i].exp_tx);
      end
      en = 1'b1;
      inv = 1'b0;
      inject_err = 1'b0;

      // PRBS7 period 127 with 64 ones
      for (int i = 0; i < 254; i++) begin
         step();
         b7[i] = tx_bit;
      end
      cnt = 0;
      for (int i = 0; i < 127; i++) if (b7[i] != b7[i+127]) cnt++;
      check("prbs7_period_mism", cnt, 0);
      cnt = 0;
      for (int i = 0; i < 127; i++) if (b7[i]) cnt++;
      check("prbs7_ones", cnt, 64);

      // Mode change to PRBS15 reseeds: 14 zeros then a one
      mode = 2'd1;
      step();
      v = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         v = (v << 1) | int'(tx_bit);
      end
      check("prbs15_reseed", v, 1);

      // PRBS31 from reset: 30 zeros, then 1, then x^31+x^28+1 recurrence
      mode = 2'd3;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step();
         o31[i] = tx_bit;
      end
      cnt = 0;
      for (int i = 0; i < 30; i++) if (o31[i]) cnt++;
      check("prbs31_lead_ones", cnt, 0);
      check("prbs31_bit31", int'(o31[30]), 1);
      cnt = 0;
      for (int m = 31; m < 3000; m++) if (o31[m] != (o31[m-31] ^ o31[m-28])) cnt++;
      check("prbs31_recur_mism", cnt, 0);

      // Loopback PRBS23: exact lock latency 23+32
      mode = 2'd2;
      for (int i = 0; i < 40; i++) step();
      chk_en = 1'b1;
      for (int i = 0; i < 54; i++) step();
      check("lock_early", locked, 0);
      step();
      check("lock_time", locked, 1);
      drops = 0;
      pulses = 0;
      for (int i = 0; i < 10000; i++) begin
         step();
         if (!locked) drops++;
         if (err_pulse) pulses++;
      end
      check("loop_drops", drops, 0);
      check("loop_pulses", pulses, 0);
      check("loop_err_cnt", err_cnt, 0);

      // Three injections 50 cycles apart
      pulses = 0;
      drops = 0;
      for (int i = 0; i < 160; i++) begin
         inject_err = (i == 0 || i == 50 || i == 100);
         step();
         if (err_pulse) pulses++;
         if (!locked) drops++;
      end
      inject_err = 1'b0;
      check("inj_pulses", pulses, 3);
      check("inj_err_cnt", err_cnt, 3);
      check("inj_drops", drops, 0);

      // Clear coincident with the detected error
      inject_err = 1'b1;
      step();
      inject_err = 1'b0;
      step();
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      check("clr_coinc_err_cnt", err_cnt, 1);
      check("clr_coinc_pulse", err_pulse, 1);
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      check("clr_err_cnt", err_cnt, 0);

      // Fresh lock so the error window starts clean
      chk_en = 1'b0;
      step();
      chk_en = 1'b1;
      for (int i = 0; i < 55; i++) step();
      check("relock", locked, 1);

      // rx stuck at 0: lock lost on the 8th error
      force0 = 1'b1;
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (err_pulse) pulses++;
         if (!locked) break;
      end
      check("stuck0_unlocked", locked, 0);
      check("stuck0_pulses", pulses, 8);
      check("stuck0_err_cnt", err_cnt, 8);

      // Checker falls into the all-zero state, then real data gives 8 more errors: saturates at 15
      for (int i = 0; i < 200 && !locked; i++) step();
      check("zero_lock", locked, 1);
      force0 = 1'b0;
      for (int i = 0; i < 300 && locked; i++) step();
      check("sat_unlocked", locked, 0);
      check("sat_err_cnt", err_cnt, 15);
      for (int i = 0; i < 300 && !locked; i++) step();
      check("sat_relock", locked, 1);
      pulses = 0;
      inject_err = 1'b1;
      step();
      inject_err = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (err_pulse) pulses++;
      end
      check("sat_inj_pulse", pulses, 1);
      check("sat_hold_err_cnt", err_cnt, 15);

      // Reset mid-lock acts without a clock edge
      check("pre_rst_locked", locked, 1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_locked", locked, 0);
      check("arst_err_cnt", err_cnt, 0);
      check("arst_err_pulse", err_pulse, 0);
      check("arst_tx_bit", tx_bit, 0);
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
